// File: rtl/peak_regfile.sv
//==============================================================================
// Module   : peak_regfile
// Purpose  : NTASK-bank x 32 x XLEN register file with two read ports, one
//            arbitrated write port (clear > debug > core), debug access and a
//            hardware bank-clear engine. Optional write-first bypass is
//            enabled by defining PEAK_REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module peak_regfile #(
    parameter int          XLEN       = 32,
    parameter int          NTASK      = 2,
    parameter logic [7:0]  AR_REGADDR = 8'h10,
    localparam int         TW         = $clog2(NTASK)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [TW-1:0]   TASKNUM,
    input  logic [4:0]      WADDR,
    input  logic            WE,
    input  logic [XLEN-1:0] WDATA,
    output logic            WREADY,
    input  logic [4:0]      RS1ADDR,
    input  logic [4:0]      RS2ADDR,
    output logic [XLEN-1:0] RS1,
    output logic [XLEN-1:0] RS2,
    input  logic            CLR_REQ,
    input  logic [TW-1:0]   CLR_TASK,
    output logic            CLR_BUSY,
    output logic            CLR_DONE,
    input  logic            AR_EN,
    input  logic            AR_WR,
    input  logic [15:0]     AR_AD,
    input  logic [XLEN-1:0] AR_DI,
    output logic [XLEN-1:0] AR_DO
);

    localparam int c_AW    = TW + 5;
    localparam int c_DEPTH = NTASK * 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_clr_idx;
    logic [4:0]      w_clr_idx_nxt;
    logic [TW-1:0]   r_clr_task;
    logic [TW-1:0]   w_clr_task_nxt;

    logic [XLEN-1:0] r_mem [0:c_DEPTH-1];

    logic            w_ar_sel;
    logic            w_ar_wr;
    logic            w_ar_rd;
    logic [c_AW-1:0] w_ar_addr;
    logic            w_clr_busy;

    logic            w_wr_en;
    logic [c_AW-1:0] w_wr_addr;
    logic [XLEN-1:0] w_wr_data;

    logic [c_AW-1:0] w_ra1;
    logic [c_AW-1:0] w_ra2;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_rz1;
    logic            w_rz2;

    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic            r_rs1_z;
    logic            r_rs2_z;
    logic [XLEN-1:0] r_ar_do;

    logic            w_unused;

    // Bank bits above the configured task width are don't-care on the debug bus
    assign w_unused   = ^AR_AD[7:5];

    assign w_ar_sel   = AR_EN && (AR_AD[15:8] == AR_REGADDR);
    assign w_ar_wr    = w_ar_sel && AR_WR;
    assign w_ar_rd    = w_ar_sel && !AR_WR;
    assign w_ar_addr  = {AR_AD[5+TW-1:5], AR_AD[4:0]};
    assign w_clr_busy = (r_state == S_CLEAR);

    assign WREADY     = !w_clr_busy && !w_ar_wr;
    assign CLR_BUSY   = w_clr_busy;
    assign CLR_DONE   = (r_state == S_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_clr_idx  <= 5'd0;
            r_clr_task <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_idx  <= w_clr_idx_nxt;
            r_clr_task <= w_clr_task_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_idx_nxt  = r_clr_idx;
        w_clr_task_nxt = r_clr_task;
        case (r_state)
            S_IDLE: begin
                if (CLR_REQ) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_idx_nxt  = 5'd0;
                    w_clr_task_nxt = CLR_TASK;
                end
            end
            S_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + 5'd1;
                if (r_clr_idx == 5'd31) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Single write port; a reset cycle suppresses the pending clear write so an
    // aborted clear leaves the current and remaining entries untouched.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_clr_busy) begin
            w_wr_en   = !RST;
            w_wr_addr = {r_clr_task, r_clr_idx};
            w_wr_data = '0;
        end else if (w_ar_wr) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_ar_addr;
            w_wr_data = AR_DI;
        end else if (WE) begin
            w_wr_en   = 1'b1;
            w_wr_addr = {TASKNUM, WADDR};
            w_wr_data = WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    assign w_ra1 = w_ar_rd ? w_ar_addr : {TASKNUM, RS1ADDR};
    assign w_ra2 = {TASKNUM, RS2ADDR};
    assign w_rz1 = (w_ra1[4:0] == 5'd0);
    assign w_rz2 = (w_ra2[4:0] == 5'd0);

`ifdef PEAK_REGFILE_BYPASS_EN
    assign w_rd1 = (w_wr_en && (w_wr_addr == w_ra1)) ? w_wr_data : r_mem[w_ra1];
    assign w_rd2 = (w_wr_en && (w_wr_addr == w_ra2)) ? w_wr_data : r_mem[w_ra2];
`else
    assign w_rd1 = r_mem[w_ra1];
    assign w_rd2 = r_mem[w_ra2];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rs1_z <= 1'b1;
            r_rs2_z <= 1'b1;
            r_ar_do <= '0;
        end else begin
            r_rs1   <= w_rd1;
            r_rs2   <= w_rd2;
            r_rs1_z <= w_rz1;
            r_rs2_z <= w_rz2;
            if (w_ar_rd) begin
                r_ar_do <= w_rz1 ? '0 : w_rd1;
            end
        end
    end

    assign RS1   = r_rs1_z ? '0 : r_rs1;
    assign RS2   = r_rs2_z ? '0 : r_rs2;
    assign AR_DO = r_ar_do;

endmodule

`default_nettype wire

// File: tb/tb_peak_regfile.sv
//==============================================================================
// Module   : tb_peak_regfile
// Purpose  : Directed bench for peak_regfile with an array-based reference
//            model compared every cycle plus hand-computed literal checks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_peak_regfile;

`ifdef PEAK_REGFILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [0:0]  tasknum;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        wready;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        clr_req;
    logic [0:0]  clr_task;
    logic        clr_busy;
    logic        clr_done;
    logic        ar_en;
    logic        ar_wr;
    logic [15:0] ar_ad;
    logic [31:0] ar_di;
    logic [31:0] ar_do;

    peak_regfile #(.XLEN(32), .NTASK(2), .AR_REGADDR(8'h10)) u_dut (
        .CLK      (clk),
        .RST      (rst),
        .TASKNUM  (tasknum),
        .WADDR    (waddr),
        .WE       (we),
        .WDATA    (wdata),
        .WREADY   (wready),
        .RS1ADDR  (rs1addr),
        .RS2ADDR  (rs2addr),
        .RS1      (rs1),
        .RS2      (rs2),
        .CLR_REQ  (clr_req),
        .CLR_TASK (clr_task),
        .CLR_BUSY (clr_busy),
        .CLR_DONE (clr_done),
        .AR_EN    (ar_en),
        .AR_WR    (ar_wr),
        .AR_AD    (ar_ad),
        .AR_DI    (ar_di),
        .AR_DO    (ar_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents plus clear progress (0 idle, 1..32 clearing entry phase-1, 33 done)
    logic [31:0] m_mem [64];
    int          m_phase = 0;
    int          m_ctask = 0;
    logic [31:0] e_rs1   = '0;
    logic [31:0] e_rs2   = '0;
    logic [31:0] e_ardo  = '0;
    bit          mdl_on  = 1'b0;

    function automatic logic [31:0] m_read(input int a, input bit wen, input int wa, input logic [31:0] wd);
        if (a % 32 == 0) return 32'h0;
        if (c_BYP && wen && (wa == a)) return wd;
        return m_mem[a];
    endfunction

    always @(posedge clk) begin
        bit          sel;
        bit          busy;
        bit          wen;
        int          wa;
        int          ra1;
        int          ra2;
        int          dba;
        logic [31:0] wd;
        logic [31:0] v1;
        logic [31:0] v2;
        sel  = ar_en && (ar_ad[15:8] == 8'h10);
        dba  = int'(ar_ad[5]) * 32 + int'(ar_ad[4:0]);
        busy = (m_phase >= 1) && (m_phase <= 32);
        wen  = 1'b0;
        wa   = 0;
        wd   = '0;
        if (busy) begin
            if (!rst) begin
                wen = 1'b1;
                wa  = m_ctask * 32 + m_phase - 1;
            end
        end else if (sel && ar_wr) begin
            wen = 1'b1;
            wa  = dba;
            wd  = ar_di;
        end else if (we) begin
            wen = 1'b1;
            wa  = int'(tasknum) * 32 + int'(waddr);
            wd  = wdata;
        end
        ra1 = (sel && !ar_wr) ? dba : int'(tasknum) * 32 + int'(rs1addr);
        ra2 = int'(tasknum) * 32 + int'(rs2addr);
        v1  = m_read(ra1, wen, wa, wd);
        v2  = m_read(ra2, wen, wa, wd);
        if (rst) begin
            e_rs1  = '0;
            e_rs2  = '0;
            e_ardo = '0;
        end else begin
            e_rs1 = v1;
            e_rs2 = v2;
            if (sel && !ar_wr) e_ardo = v1;
        end
        if (wen) m_mem[wa] = wd;
        if (rst)                    m_phase = 0;
        else if (m_phase == 0)      begin
            if (clr_req) begin
                m_phase = 1;
                m_ctask = int'(clr_task);
            end
        end
        else if (m_phase == 33)     m_phase = 0;
        else                        m_phase = m_phase + 1;
    end

    always @(negedge clk) begin
        bit busy_now;
        #2;
        if (mdl_on) begin
            busy_now = (m_phase >= 1) && (m_phase <= 32);
            chk("m_rs1", rs1, e_rs1);
            chk("m_rs2", rs2, e_rs2);
            chk("m_ar_do", ar_do, e_ardo);
            chk("m_clr_busy", 32'(clr_busy), 32'(busy_now));
            chk("m_clr_done", 32'(clr_done), 32'(m_phase == 33));
            chk("m_wready", 32'(wready),
                32'(!busy_now && !(ar_en && ar_wr && (ar_ad[15:8] == 8'h10))));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_core(input logic [0:0] t, input int a, input logic [31:0] d);
        tasknum = t;
        waddr   = 5'(a);
        wdata   = d;
        we      = 1'b1;
        step();
        we      = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tasknum = '0; waddr = '0; we = 1'b0; wdata = '0;
        rs1addr = '0; rs2addr = '0; clr_req = 1'b0; clr_task = '0;
        ar_en = 1'b0; ar_wr = 1'b0; ar_ad = '0; ar_di = '0;
        repeat (3) step();
        rst    = 1'b0;
        mdl_on = 1'b1;
        chk("rst_rs1", rs1, 32'h0);
        chk("rst_rs2", rs2, 32'h0);
        chk("rst_ar_do", ar_do, 32'h0);
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        chk("rst_clr_done", 32'(clr_done), 32'h0);
        #1 chk("rst_wready", 32'(wready), 32'h1);

        // Fill: bank b, index i = 0x1000_0000*(b+1) + 0x0001_0101*i
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 32; i++)
                wr_core(1'(b), i, 32'h1000_0000 * (b + 1) + 32'h0001_0101 * i);

        // Bank-separated write and read
        wr_core(1'b1, 5, 32'hDEADBEEF);
        tasknum = 1'b1; rs1addr = 5'd5; step();
        chk("t1_x5", rs1, 32'hDEADBEEF);
        tasknum = 1'b0; step();
        chk("t0_x5", rs1, 32'h10050505);

        // Same-cycle write/read of x7
        wr_core(1'b0, 7, 32'h1);
        tasknum = 1'b0; waddr = 5'd7; wdata = 32'hA5A5A5A5; we = 1'b1; rs1addr = 5'd7;
        step();
        we = 1'b0;
        chk("bypass_x7", rs1, c_BYP ? 32'hA5A5A5A5 : 32'h1);
        step();
        chk("after_x7", rs1, 32'hA5A5A5A5);

        // Debug write collides with core write
        ar_en = 1'b1; ar_wr = 1'b1; ar_ad = 16'h1023; ar_di = 32'hCAFEF00D;
        tasknum = 1'b0; waddr = 5'd9; wdata = 32'h99; we = 1'b1;
        #1 chk("ar_stall_wready", 32'(wready), 32'h0);
        step();
        ar_en = 1'b0;
        #1 chk("ar_release_wready", 32'(wready), 32'h1);
        step();
        we = 1'b0;
        ar_en = 1'b1; ar_wr = 1'b0; ar_ad = 16'h1023; step();
        chk("ar_rd_b1x3", ar_do, 32'hCAFEF00D);
        ar_en = 1'b0; rs1addr = 5'd9; step();
        chk("core_x9", rs1, 32'h99);
        ar_en = 1'b1; ar_wr = 1'b1; ar_ad = 16'h2003; ar_di = 32'h0BADBAD0;
        #1 chk("unsel_wready", 32'(wready), 32'h1);
        step();
        ar_wr = 1'b0; ar_ad = 16'h1003; step();
        chk("unsel_nowrite", ar_do, 32'h10030303);

        // x0 always reads zero
        ar_en = 1'b0;
        wr_core(1'b0, 0, 32'h12345678);
        rs1addr = 5'd0; rs2addr = 5'd0; step();
        chk("x0_rs1", rs1, 32'h0);
        chk("x0_rs2", rs2, 32'h0);
        ar_en = 1'b1; ar_wr = 1'b0; ar_ad = 16'h1000; step();
        chk("x0_ar_do", ar_do, 32'h0);
        ar_en = 1'b0;

        // Bank clear with a stalled core write
        clr_req = 1'b1; clr_task = 1'b1; step();
        clr_req = 1'b0;
        tasknum = 1'b0; waddr = 5'd12; wdata = 32'h1212; we = 1'b1;
        for (int k = 0; k < 32; k++) begin
            #1;
            chk("clr_busy", 32'(clr_busy), 32'h1);
            chk("clr_wready", 32'(wready), 32'h0);
            clr_req = (k == 5);
            rs1addr = 5'(k);
            rs2addr = 5'(31 - k);
            step();
        end
        clr_req = 1'b0;
        chk("clr_done", 32'(clr_done), 32'h1);
        chk("clr_busy_end", 32'(clr_busy), 32'h0);
        step();
        we = 1'b0;
        chk("clr_done_pulse", 32'(clr_done), 32'h0);
        tasknum = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1addr = 5'(i); rs2addr = 5'(31 - i); step();
            chk("cleared_b1", rs1, 32'h0);
        end
        tasknum = 1'b0; rs1addr = 5'd12; step();
        chk("b0_x12", rs1, 32'h1212);
        rs1addr = 5'd13; step();
        chk("b0_x13", rs1, 32'h100D0D0D);

        // Reset aborts a clear at entry 10
        for (int i = 0; i < 32; i++) wr_core(1'b1, i, 32'h5000 + i);
        clr_req = 1'b1; clr_task = 1'b1; step();
        clr_req = 1'b0;
        repeat (10) step();
        rst = 1'b1; step();
        rst = 1'b0;
        chk("abort_busy", 32'(clr_busy), 32'h0);
        chk("abort_done", 32'(clr_done), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_done", 32'(clr_done), 32'h0);
        end
        tasknum = 1'b1; rs1addr = 5'd9; step();
        chk("abort_x9", rs1, 32'h0);
        rs1addr = 5'd10; step();
        chk("abort_x10", rs1, 32'h500A);
        rs1addr = 5'd31; step();
        chk("abort_x31", rs1, 32'h501F);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/peak_regfile.md
# peak_regfile

Multi-task integer register file for the peak core, the parametrised successor of the two-task file. Holds NTASK banks of 32 XLEN-bit registers with two synchronous read ports, one shared write port and a debug (AR) access path. Adds write-to-read bypass and a hardware bank-clear engine so a task context can be zeroed without software loops. Sits between decode (read addresses) and writeback (write port) in the core pipeline.

## Interface
- XLEN, 32, register width
- NTASK, 2, number of task banks; power of two, ≥2; TW = $clog2(NTASK)
- AR_REGADDR, 8'h10, AR_AD[15:8] value selecting the register file on the debug bus

- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- TASKNUM  in  TW  active task bank for core reads/writes
- WADDR  in  5  core write register index
- WE  in  1  core write request
- WDATA  in  XLEN  core write data
- WREADY  out  1  core write accepted this cycle
- RS1ADDR, RS2ADDR  in  5 each  core read indices
- RS1, RS2  out  XLEN each  read data, 1-cycle latency
- CLR_REQ  in  1  start bank clear
- CLR_TASK  in  TW  bank to clear
- CLR_BUSY  out  1  clear in progress
- CLR_DONE  out  1  one-cycle clear-complete pulse
- AR_EN, AR_WR  in  1 each  debug access strobe / write
- AR_AD  in  16  debug address: [15:8] block select, [5+TW-1:5] bank, [4:0] register
- AR_DI  in  XLEN  debug write data
- AR_DO  out  XLEN  debug read data, 1-cycle latency

## Operation
- AR_SEL = AR_EN & (AR_AD[15:8] == AR_REGADDR). Debug write occurs only when AR_SEL & AR_WR; unselected AR cycles never write.
- Write-port priority: clear engine > debug write > core write. WREADY = !CLR_BUSY & !(AR_SEL & AR_WR). Core write happens iff WE & WREADY; core holds WE/WADDR/WDATA until WREADY.
- Core write address {TASKNUM, WADDR}; debug write address {AR_AD bank, AR_AD[4:0]}.
- Read port 1 address = debug address when AR_SEL & !AR_WR, else {TASKNUM, RS1ADDR}; read port 2 always {TASKNUM, RS2ADDR}. RS1 undefined for core use during a debug read cycle.
- Register index 0 of every bank reads 0 regardless of contents (zero flag registered alongside data, computed on the 5-bit index only).
- AR_DO registered from port 1 on debug read cycles; holds value otherwise.
- Clear FSM: IDLE -> CLEAR on CLR_REQ; CLEAR writes 0 to index 0..31 of CLR_TASK (latched at entry), one per cycle, 32 cycles; index 31 -> DONE; DONE (1 cycle, CLR_DONE=1) -> IDLE. CLR_BUSY=1 in CLEAR only. CLR_REQ outside IDLE ignored.
- Read during CLEAR of a clearing entry follows bypass rules below.

## Timing
- Reset: FSM IDLE, RS1=RS2=0, AR_DO=0, CLR_BUSY=0, CLR_DONE=0, WREADY=1 (absent AR write). Array contents not reset.
- Read: address at edge N, data on RS1/RS2 after edge N, stable until next edge.
- Same-cycle write and read of identical {bank,index}: new data returned with bypass compiled in, old data without.
- Write visible to reads issued at edge N+1.
- Reset during CLEAR: abort immediately, no CLR_DONE, partially cleared bank left as is.
- CLR_REQ at edge N: CLR_BUSY high N+1..N+32, CLR_DONE at N+33.

## Configuration
- PEAK_REGFILE_BYPASS_EN defined: write-first — a read matching the write actually performed in the same cycle (any source, including clear) returns the written data; index 0 still reads 0.
- Undefined: read-first, returns pre-write contents; no bypass muxes.

## Test plan
- Write T1 x5=0xDEADBEEF, then read RS1ADDR=5 TASKNUM=1 -> RS1=0xDEADBEEF next cycle; TASKNUM=0 read x5 unaffected.
- Write x0=0x12345678 -> RS1/RS2 of x0 read 0; debug read of AR_AD=0x1000 -> AR_DO=0.
- Same-cycle write x7=0xA5A5A5A5 and read x7 (old 0x1) -> 0xA5A5A5A5 with PEAK_REGFILE_BYPASS_EN, 0x1 without.
- AR_AD=0x1023 write 0xCAFEF00D (NTASK=2 -> bank1 x3) concurrent core WE -> WREADY=0, core write lands next cycle; AR_AD=0x2003 write -> no array change.
- Fill bank 1 with nonzero, CLR_REQ CLR_TASK=1 -> CLR_BUSY 32 cycles, CLR_DONE pulse, all bank1 reads 0, bank0 intact; core WE stalled throughout.
- RST asserted at clear cycle 10 -> CLR_BUSY=0 next cycle, no CLR_DONE, x10..x31 of bank retain old values.
